// File: rtl/instr_prefetch_pkg.sv
// Shared constants, FSM state encoding and helpers for the instruction prefetch queue.
package instr_prefetch_pkg;

    localparam int unsigned IMEM_WORD_BYTES = 8;
    localparam int unsigned MAX_INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_REQ  = 2'd1,
        PF_WAIT = 2'd2,
        PF_DROP = 2'd3
    } pf_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instr_prefetch_byteq.sv
// prefetch_byteq: byte shift queue with per-byte error flag, variable pop (0..10) and
// push (0..8) per cycle; pop is applied before push. Exposes the first 10 bytes.
module prefetch_byteq
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 24
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 flush_i,
    input  logic [3:0]                           pop_len_i,
    input  logic [3:0]                           push_len_i,
    input  logic [63:0]                          push_data_i,
    input  logic                                 push_err_i,
    output logic [8*MAX_INSTR_BYTES-1:0]         win_data_o,
    output logic [MAX_INSTR_BYTES-1:0]           win_err_o,
    output logic [$clog2(BUF_BYTES+1)-1:0]       count_o
);

    localparam int unsigned CW = $clog2(BUF_BYTES + 1);
    localparam int unsigned DW = 8 * BUF_BYTES;

    logic [DW-1:0]        data_q, data_d, popped_d, pushed_d, push_wide;
    logic [BUF_BYTES-1:0] err_q, err_d, popped_e;
    logic [CW-1:0]        count_q, count_d;
    int unsigned          cnt, kept, plen;

    // Bytes below 'kept' come from the shifted-down queue, the next 'plen' from the new word.
    always_comb begin
        cnt       = 32'(count_q);
        kept      = cnt - 32'(pop_len_i);
        plen      = 32'(push_len_i);
        push_wide = '0;
        push_wide[63:0] = push_data_i;
        popped_d  = data_q >> (8 * 32'(pop_len_i));
        popped_e  = err_q >> pop_len_i;
        pushed_d  = push_wide << (8 * kept);
        data_d    = '0;
        err_d     = '0;
        for (int unsigned i = 0; i < BUF_BYTES; i++) begin
            if (i < kept) begin
                data_d[8*i +: 8] = popped_d[8*i +: 8];
                err_d[i]         = popped_e[i];
            end else if (i < kept + plen) begin
                data_d[8*i +: 8] = pushed_d[8*i +: 8];
                err_d[i]         = push_err_i;
            end
        end
        count_d = CW'(kept + plen);
        if (flush_i) begin
            data_d  = '0;
            err_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            err_q   <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        win_data_o = '0;
        win_err_o  = '0;
        for (int unsigned k = 0; k < MAX_INSTR_BYTES; k++) begin
            if (k < cnt) begin
                win_data_o[8*k +: 8] = data_q[8*k +: 8];
                win_err_o[k]         = err_q[k];
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetch FSM, fetch address/skip/PC registers and optional
// statistics counters (enabled by defining PREFETCH_STATS_EN).
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned BUF_BYTES = 24
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        req_valid_o,
    output logic [63:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        resp_valid_i,
    input  logic [63:0] resp_data_i,
    input  logic        resp_err_i,
    output logic [79:0] win_bytes_o,
    output logic [63:0] win_pc_o,
    output logic [4:0]  avail_o,
    output logic        imem_error_o,
    input  logic        consume_i,
    input  logic [3:0]  consume_len_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] stat_stall_o,
    output logic [31:0] stat_flush_o
`endif
);

    localparam int unsigned CW = $clog2(BUF_BYTES + 1);

    pf_state_t             state_q, state_d;
    logic [63:0]           fetch_addr_q, win_pc_q;
    logic [2:0]            skip_q;
    logic [CW-1:0]         q_count;
    logic [MAX_INSTR_BYTES-1:0] win_err;
    logic                  accept, space_ok, resp_take, consume_ok;
    logic [3:0]            pop_len, push_len;
    logic [63:0]           push_data;

    always_comb begin
        accept     = (state_q == PF_REQ) && req_ready_i;
        space_ok   = (32'(q_count) + IMEM_WORD_BYTES) <= BUF_BYTES;
        resp_take  = (state_q == PF_WAIT) && resp_valid_i && !redirect_i;
        avail_o    = (32'(q_count) >= MAX_INSTR_BYTES) ? 5'(MAX_INSTR_BYTES) : 5'(q_count);
        consume_ok = consume_i && (consume_len_i != 4'd0) && ({1'b0, consume_len_i} <= avail_o);
        pop_len    = (consume_ok && !redirect_i) ? consume_len_i : 4'd0;
        push_len   = resp_take ? (4'd8 - {1'b0, skip_q}) : 4'd0;
        push_data  = resp_data_i >> {skip_q, 3'b000};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= PF_IDLE;
        else          state_q <= state_d;
    end

    // A response arriving in the same cycle as a redirect retires the outstanding request,
    // so there is nothing left to drop and the FSM returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PF_IDLE: if (redirect_i || space_ok) state_d = PF_REQ;
            PF_REQ: begin
                if (redirect_i)  state_d = accept ? PF_DROP : PF_IDLE;
                else if (accept) state_d = PF_WAIT;
            end
            PF_WAIT: begin
                if (resp_valid_i)    state_d = PF_IDLE;
                else if (redirect_i) state_d = PF_DROP;
            end
            PF_DROP: if (resp_valid_i) state_d = PF_IDLE;
            default: state_d = PF_IDLE;
        endcase
    end

    always_comb begin
        req_valid_o = (state_q == PF_REQ);
        req_addr_o  = (state_q == PF_REQ) ? fetch_addr_q : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_addr_q <= {RESET_PC[63:3], 3'b000};
            skip_q       <= RESET_PC[2:0];
            win_pc_q     <= RESET_PC;
        end else if (redirect_i) begin
            fetch_addr_q <= {redirect_pc_i[63:3], 3'b000};
            skip_q       <= redirect_pc_i[2:0];
            win_pc_q     <= redirect_pc_i;
        end else begin
            if (resp_take) begin
                fetch_addr_q <= fetch_addr_q + 64'd8;
                skip_q       <= 3'd0;
            end
            if (consume_ok) win_pc_q <= win_pc_q + 64'(consume_len_i);
        end
    end

    prefetch_byteq #(
        .BUF_BYTES(BUF_BYTES)
    ) u_byteq (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (redirect_i),
        .pop_len_i   (pop_len),
        .push_len_i  (push_len),
        .push_data_i (push_data),
        .push_err_i  (resp_err_i),
        .win_data_o  (win_bytes_o),
        .win_err_o   (win_err),
        .count_o     (q_count)
    );

    // win_err is already masked to the valid bytes, and avail_o never exceeds the window size.
    assign imem_error_o = |win_err;
    assign win_pc_o     = win_pc_q;

`ifdef PREFETCH_STATS_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((avail_o < 5'(MAX_INSTR_BYTES)) && !redirect_i) stall_q <= sat_inc32(stall_q);
            if (redirect_i) flush_q <= sat_inc32(flush_q);
        end
    end

    assign stat_stall_o = stall_q;
    assign stat_flush_o = flush_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: memory byte at address a holds a[7:0].
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_data  = '0;
    logic        resp_err   = 1'b0;
    logic [79:0] win_bytes;
    logic [63:0] win_pc;
    logic [4:0]  avail;
    logic        imem_error;
    logic        consume;
    logic [3:0]  len;
    logic        redirect;
    logic [63:0] rpc;
`ifdef PREFETCH_STATS_EN
    logic [31:0] stat_stall, stat_flush;
`endif

    int checks   = 0;
    int failures = 0;

    instr_prefetch #(
        .RESET_PC  (64'h0),
        .BUF_BYTES (24)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_valid_o   (req_valid),
        .req_addr_o    (req_addr),
        .req_ready_i   (req_ready),
        .resp_valid_i  (resp_valid),
        .resp_data_i   (resp_data),
        .resp_err_i    (resp_err),
        .win_bytes_o   (win_bytes),
        .win_pc_o      (win_pc),
        .avail_o       (avail),
        .imem_error_o  (imem_error),
        .consume_i     (consume),
        .consume_len_i (len),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_stall_o  (stat_stall),
        .stat_flush_o  (stat_flush)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one outstanding read, response 'lat' cycles after accept.
    int unsigned lat      = 1;
    logic        pend     = 1'b0;
    int unsigned pcnt     = 0;
    logic [63:0] paddr    = '0;
    logic [63:0] err_addr = '1;
    logic [63:0] tmp_a;

    always @(negedge clk) begin
        #1;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
        if (pend) begin
            if (pcnt == 0) begin
                resp_valid = 1'b1;
                resp_err   = (paddr == err_addr);
                for (int k = 0; k < 8; k++) begin
                    tmp_a = paddr + 64'(k);
                    resp_data[8*k +: 8] = tmp_a[7:0];
                end
                pend = 1'b0;
            end else begin
                pcnt = pcnt - 1;
            end
        end
        if (req_valid && req_ready) begin
            pend  = 1'b1;
            paddr = req_addr;
            pcnt  = lat - 1;
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [63:0] pc);
        logic [79:0] e, a;
        logic [63:0] ad;
        e = '0;
        a = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < int'(avail)) begin
                ad = pc + 64'(k);
                e[8*k +: 8] = ad[7:0];
                a[8*k +: 8] = win_bytes[8*k +: 8];
            end
        end
        check(name, a, e);
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        @(negedge clk);
        redirect = 1'b1;
        rpc      = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 80'(req_valid), 80'd0);
        check({tag, "_req_addr"},  80'(req_addr),  80'd0);
        check({tag, "_win_bytes"}, win_bytes,      80'd0);
        check({tag, "_win_pc"},    80'(win_pc),    80'd0);
        check({tag, "_avail"},     80'(avail),     80'd0);
        check({tag, "_imem_err"},  80'(imem_error), 80'd0);
    endtask

    typedef struct {
        logic        consume;
        logic [3:0]  len;
        logic        redirect;
        logic [63:0] rpc;
        logic [63:0] exp_pc;
        logic [4:0]  exp_avail;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; req_ready = 1'b1; consume = 1'b0; len = '0; redirect = 1'b0; rpc = '0;
        tbl[0] = '{1'b1, 4'd10, 1'b0, 64'h0,  64'd10,  5'd10};
        tbl[1] = '{1'b1, 4'd2,  1'b0, 64'h0,  64'd12,  5'd10};
        tbl[2] = '{1'b1, 4'd1,  1'b0, 64'h0,  64'd13,  5'd10};
        tbl[3] = '{1'b1, 4'd0,  1'b0, 64'h0,  64'd13,  5'd10};
        tbl[4] = '{1'b1, 4'd15, 1'b0, 64'h0,  64'd13,  5'd10};
        tbl[5] = '{1'b1, 4'd3,  1'b1, 64'h40, 64'h40,  5'd0};

        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // first word, then fill to a full window
        n = 0;
        while (avail == 0 && n < 50) begin @(negedge clk); n++; end
        check("t1_first_timeout", 80'(avail != 0), 80'd1);
        check("t1_avail_first", 80'(avail), 80'd8);
        check("t1_pc", 80'(win_pc), 80'd0);
        check_win("t1_first_word", 64'h0);
        n = 0;
        while (avail != 10 && n < 50) begin @(negedge clk); n++; end
        check("t1_avail_full", 80'(avail), 80'd10);
        check_win("t1_window", 64'h0);
        repeat (12) @(negedge clk);

        // back-to-back consumes, ignored lengths, then redirect overriding a consume
        for (int i = 0; i < 6; i++) begin
            consume = tbl[i].consume; len = tbl[i].len;
            redirect = tbl[i].redirect; rpc = tbl[i].rpc;
            @(negedge clk);
            consume = 1'b0; len = '0; redirect = 1'b0;
            check($sformatf("t2_pc_%0d", i), 80'(win_pc), 80'(tbl[i].exp_pc));
            check($sformatf("t2_avail_%0d", i), 80'(avail), 80'(tbl[i].exp_avail));
            check_win($sformatf("t2_win_%0d", i), tbl[i].exp_pc);
        end

        // redirect while a read is outstanding; stale word must be dropped
        lat = 4;
        n = 0;
        while (!req_valid && n < 50) begin @(negedge clk); n++; end
        check("t3_req_seen", 80'(req_valid), 80'd1);
        @(negedge clk);
        redirect = 1'b1; rpc = 64'h2B;
        @(negedge clk);
        redirect = 1'b0;
        check("t3_drop_req_valid", 80'(req_valid), 80'd0);
        check("t3_pc", 80'(win_pc), 80'h2B);
        check("t3_avail_flush", 80'(avail), 80'd0);
        lat = 1;
        n = 0;
        while (!req_valid && n < 50) begin @(negedge clk); n++; end
        check("t3_req_addr", 80'(req_addr), 80'h28);
        n = 0;
        while (avail == 0 && n < 50) begin @(negedge clk); n++; end
        check("t3_avail", 80'(avail), 80'd5);
        check_win("t3_window", 64'h2B);

        // memory not ready: request held stable
        req_ready = 1'b0;
        do_redirect(64'h100);
        n = 0;
        while (!req_valid && n < 50) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4_hold_%0d", c), 80'({req_valid, req_addr, avail}),
                  80'({1'b1, 64'h100, 5'd0}));
            @(negedge clk);
        end
        req_ready = 1'b1;
        n = 0;
        while (avail == 0 && n < 50) begin @(negedge clk); n++; end
        check("t4_avail", 80'(avail), 80'd8);
        check_win("t4_window", 64'h100);

        // error word at 0x10 seen only once it enters the window from 0x0C
        err_addr = 64'h10;
        do_redirect(64'h0C);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("t5_err_%0d", c), 80'(imem_error), 80'(avail > 5'd4));
            if (avail == 5'd10) break;
        end
        check("t5_avail_full", 80'(avail), 80'd10);
        err_addr = '1;
        do_redirect(64'h0);
        check("t5_err_cleared", 80'(imem_error), 80'd0);
        check("t5_avail_cleared", 80'(avail), 80'd0);

        // reset while a read is outstanding
        lat = 4;
        do_redirect(64'h1A8);
        n = 0;
        while (!req_valid && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 1'b0; req_ready = 1'b0;
        #1;
        check_reset_outputs("t6");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t6_idle_%0d", c), 80'({win_pc, avail}), 80'({64'h0, 5'd0}));
        end
        lat = 1; req_ready = 1'b1;
        n = 0;
        while (avail == 0 && n < 50) begin @(negedge clk); n++; end
        check("t6_pc", 80'(win_pc), 80'd0);
        check("t6_avail", 80'(avail), 80'd8);
        check_win("t6_window", 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
